// File: rtl/pe_req_bridge.sv
// Registered demux-to-interconnect request bridge with ID-filtered, one-cycle-delayed responses.
// Request out 1 cycle after accept; responses 1 cycle after arrival with no backpressure; gnt_o stalls while a request is held or outstanding is full.
module pe_req_bridge #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = 4,
   parameter int unsigned ID_WIDTH        = 5,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   core_id_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] add_i,
   input  logic                  type_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic [DATA_WIDTH-1:0] r_rdata_o,
   output logic                  r_opc_o,
   output logic                  busy_o,
   output logic                  req_o,
   output logic [ADDR_WIDTH-1:0] add_o,
   output logic                  type_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [BE_WIDTH-1:0]   be_o,
   output logic [ID_WIDTH-1:0]   id_o,
   input  logic                  gnt_i,
   input  logic                  r_valid_i,
   input  logic [ID_WIDTH-1:0]   r_id_i,
   input  logic                  r_opc_i,
   input  logic [DATA_WIDTH-1:0] r_rdata_i,
   output logic                  spurious_o
);

   localparam int unsigned        CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   typedef enum logic {IDLE = 1'b0, WAIT_GNT = 1'b1} state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] add;
      logic                  typ;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
      logic [ID_WIDTH-1:0]   id;
   } req_t;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   req_t                  req_q, req_d;
   logic                  r_valid_q, r_valid_d;
   logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
   logic                  r_opc_q, r_opc_d;
   logic                  spurious_q, spurious_d;

   logic id_hit, rsp_match, rsp_spur, granted;

   // gnt_o is decoded from registers only, so req_i never reaches gnt_i combinationally.
   assign gnt_o     = (state_q == IDLE) && (cnt_q < CNT_MAX);
   assign busy_o    = (state_q == WAIT_GNT) || (cnt_q != '0);
   assign granted   = (state_q == WAIT_GNT) && gnt_i;
   assign id_hit    = r_valid_i && (r_id_i == core_id_i);
   assign rsp_match = id_hit && (cnt_q != '0);
   assign rsp_spur  = id_hit && (cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      r_valid_d  = rsp_match;
      spurious_d = rsp_spur;
      r_rdata_d  = r_rdata_q;
      r_opc_d    = r_opc_q;

      case (state_q)
         IDLE: begin
            if (req_i && gnt_o) begin
               state_d = WAIT_GNT;
               req_d   = '{add: add_i, typ: type_i, wdata: wdata_i, be: be_i, id: core_id_i};
            end
         end
         WAIT_GNT: begin
            if (gnt_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rsp_match) begin
         r_rdata_d = r_rdata_i;
         r_opc_d   = r_opc_i;
      end

      // A grant and a matched response in the same cycle cancel out.
      case ({granted, rsp_match})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_q      <= '0;
         r_valid_q  <= 1'b0;
         r_rdata_q  <= '0;
         r_opc_q    <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         r_valid_q  <= r_valid_d;
         r_rdata_q  <= r_rdata_d;
         r_opc_q    <= r_opc_d;
         spurious_q <= spurious_d;
      end
   end

   assign req_o      = (state_q == WAIT_GNT);
   assign add_o      = req_q.add;
   assign type_o     = req_q.typ;
   assign wdata_o    = req_q.wdata;
   assign be_o       = req_q.be;
   assign id_o       = req_q.id;
   assign r_valid_o  = r_valid_q;
   assign r_rdata_o  = r_rdata_q;
   assign r_opc_o    = r_opc_q;
   assign spurious_o = spurious_q;

endmodule

// File: tb/tb_pe_req_bridge.sv
// Bench for pe_req_bridge: directed scenarios then random traffic against a transaction-level model.
module tb_pe_req_bridge;

   localparam int MAXO = 2;
   localparam logic [4:0] CORE = 5'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  core_id_i;
   logic        req_i, type_i, gnt_i, r_valid_i, r_opc_i;
   logic [31:0] add_i, wdata_i, r_rdata_i;
   logic [3:0]  be_i;
   logic [4:0]  r_id_i;
   logic        gnt_o, r_valid_o, r_opc_o, busy_o, req_o, type_o, spurious_o;
   logic [31:0] r_rdata_o, add_o, wdata_o;
   logic [3:0]  be_o;
   logic [4:0]  id_o;

   int n_cmp = 0;
   int n_err = 0;

   // Model: a held request (at most one), a count of granted-unanswered requests,
   // and what the response side should show in the following cycle.
   bit          m_pend;
   int          m_out;
   logic [31:0] m_add, m_wdata, m_rdata;
   logic        m_type, m_ropc, m_rv, m_spur;
   logic [3:0]  m_be;
   logic [4:0]  m_id;

   always #5 clk = ~clk;

   pe_req_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(5),
                   .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .core_id_i(core_id_i),
      .req_i(req_i), .add_i(add_i), .type_i(type_i), .wdata_i(wdata_i), .be_i(be_i),
      .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
      .busy_o(busy_o), .req_o(req_o), .add_o(add_o), .type_o(type_o), .wdata_o(wdata_o),
      .be_o(be_o), .id_o(id_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_id_i(r_id_i),
      .r_opc_i(r_opc_i), .r_rdata_i(r_rdata_i), .spurious_o(spurious_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_update();
      bit granted, hit, accept;
      if (!rst_n) begin
         m_pend = 0; m_out = 0; m_rv = 0; m_spur = 0; m_rdata = '0; m_ropc = 0;
         m_add = '0; m_wdata = '0; m_type = 0; m_be = '0; m_id = '0;
         return;
      end
      granted = m_pend && gnt_i;
      hit     = r_valid_i && (r_id_i == core_id_i);
      accept  = !m_pend && (m_out < MAXO) && req_i;
      m_rv    = hit && (m_out > 0);
      m_spur  = hit && (m_out == 0);
      if (m_rv) begin m_rdata = r_rdata_i; m_ropc = r_opc_i; end
      m_out = m_out + (granted ? 1 : 0) - (m_rv ? 1 : 0);
      if (granted) m_pend = 0;
      if (accept) begin
         m_pend = 1; m_add = add_i; m_type = type_i; m_wdata = wdata_i; m_be = be_i; m_id = core_id_i;
      end
   endfunction

   task automatic check_all();
      chk("req_o",      64'(req_o),      64'(m_pend));
      chk("gnt_o",      64'(gnt_o),      64'(!m_pend && m_out < MAXO));
      chk("busy_o",     64'(busy_o),     64'(m_pend || m_out != 0));
      chk("r_valid_o",  64'(r_valid_o),  64'(m_rv));
      chk("spurious_o", 64'(spurious_o), 64'(m_spur));
      if (m_rv) begin
         chk("r_rdata_o", 64'(r_rdata_o), 64'(m_rdata));
         chk("r_opc_o",   64'(r_opc_o),   64'(m_ropc));
      end
      if (m_pend) begin
         chk("add_o",   64'(add_o),   64'(m_add));
         chk("type_o",  64'(type_o),  64'(m_type));
         chk("wdata_o", 64'(wdata_o), 64'(m_wdata));
         chk("be_o",    64'(be_o),    64'(m_be));
         chk("id_o",    64'(id_o),    64'(m_id));
      end
   endtask

   // Inputs are changed at the falling edge; the model advances on what the rising edge will sample.
   task automatic tick();
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic quiet();
      req_i = 0; gnt_i = 0; r_valid_i = 0; r_id_i = CORE; r_opc_i = 0;
      r_rdata_i = $urandom; add_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom); type_i = 0;
   endtask

   task automatic do_req(input logic [31:0] a, input logic t);
      quiet(); req_i = 1; add_i = a; type_i = t; tick(); quiet();
   endtask

   task automatic do_gnt();
      quiet(); gnt_i = 1; tick(); quiet();
   endtask

   task automatic do_rsp(input logic [4:0] id, input logic [31:0] d);
      quiet(); r_valid_i = 1; r_id_i = id; r_rdata_i = d; r_opc_i = 1'($urandom); tick(); quiet();
   endtask

   initial begin
      core_id_i = CORE;
      rst_n = 0;
      quiet();
      tick();
      rst_n = 1;
      chk("rst_add_o",   64'(add_o),     64'(0));
      chk("rst_wdata_o", 64'(wdata_o),   64'(0));
      chk("rst_id_o",    64'(id_o),      64'(0));
      chk("rst_rdata_o", 64'(r_rdata_o), 64'(0));
      chk("rst_r_opc_o", 64'(r_opc_o),   64'(0));
      chk("rst_gnt_o",   64'(gnt_o),     64'(1));

      // Single read
      do_req(32'h1A10_0004, 1'b1);
      chk("rd_add_o", 64'(add_o), 64'h1A10_0004);
      chk("rd_id_o",  64'(id_o),  64'(CORE));
      do_gnt();
      chk("rd_busy_after_gnt", 64'(busy_o), 64'(1));
      do_rsp(CORE, 32'hDEAD_BEEF);
      chk("rd_rdata", 64'(r_rdata_o), 64'hDEAD_BEEF);
      tick();
      chk("rd_busy_done", 64'(busy_o), 64'(0));

      // Grant stall: demux keeps presenting new payloads that must not be taken
      do_req(32'h2000_0010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         req_i = 1; add_i = $urandom; wdata_i = $urandom;
         tick();
         chk("stall_gnt_o", 64'(gnt_o), 64'(0));
         chk("stall_add_o", 64'(add_o), 64'h2000_0010);
      end
      do_gnt();
      do_rsp(CORE, $urandom);

      // Outstanding limit
      do_req(32'h3000_0000, 1'b0); do_gnt();
      do_req(32'h3000_0004, 1'b0); do_gnt();
      chk("lim_gnt_o", 64'(gnt_o), 64'(0));
      req_i = 1; tick(); quiet();
      chk("lim_no_req", 64'(req_o), 64'(0));
      do_rsp(CORE, 32'h1111_2222);
      chk("lim_gnt_back", 64'(gnt_o), 64'(1));

      // Same-cycle grant and matched response with one outstanding
      do_req(32'h4000_0000, 1'b1);
      gnt_i = 1; r_valid_i = 1; r_id_i = CORE; r_rdata_i = 32'hCAFE_F00D;
      tick(); quiet();
      chk("same_rv", 64'(r_valid_o), 64'(1));
      chk("same_busy", 64'(busy_o), 64'(1));
      do_rsp(CORE, $urandom);
      chk("same_drained", 64'(busy_o), 64'(0));

      // ID filtering and spurious responses
      do_req(32'h5000_0000, 1'b1); do_gnt();
      do_rsp(CORE + 5'd1, $urandom);
      chk("foreign_rv", 64'(r_valid_o), 64'(0));
      chk("foreign_busy", 64'(busy_o), 64'(1));
      do_rsp(CORE, $urandom);
      do_rsp(CORE, $urandom);
      chk("spur_pulse", 64'(spurious_o), 64'(1));
      tick();

      // Reset while holding a request with one outstanding
      do_req(32'h6000_0000, 1'b0); do_gnt();
      do_req(32'h6000_0004, 1'b1);
      rst_n = 0; tick(); rst_n = 1;
      chk("rst_mid_req", 64'(req_o), 64'(0));
      chk("rst_mid_busy", 64'(busy_o), 64'(0));
      chk("rst_mid_gnt", 64'(gnt_o), 64'(1));
      do_rsp(CORE, $urandom);
      chk("rst_mid_spur", 64'(spurious_o), 64'(1));

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         req_i     = ($urandom_range(0, 1) == 1);
         add_i     = $urandom;
         type_i    = 1'($urandom);
         wdata_i   = $urandom;
         be_i      = 4'($urandom);
         gnt_i     = ($urandom_range(0, 9) < 4);
         r_valid_i = ($urandom_range(0, 9) < 3);
         r_id_i    = ($urandom_range(0, 9) < 7) ? CORE : 5'($urandom);
         r_opc_i   = 1'($urandom);
         r_rdata_i = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
